// File: rtl/result_tx_pkg.sv
// -----------------------------------------------------------------------------
// result_tx_pkg
// Shared types and constants for the result UART transmitter.
//   tx_state_t  : transmitter FSM state encoding
//   DATA_BITS   : payload width of one frame
//   IDLE_LEVEL  : line level while idle (also the stop-bit level)
//   START_LEVEL : line level of the start bit
// Optional feature macro: RESULT_TX_PARITY_EN adds the PARITY state.
// -----------------------------------------------------------------------------
package result_tx_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

`ifdef RESULT_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;
`endif

endpackage

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Bit-period counter for the result UART transmitter. Counts 0..CLKS_PER_BIT-1
// and wraps, so every bit boundary reloads the period automatically.
//   clk     : system clock (rising edge)
//   reset   : asynchronous, active-high; clears the counter
//   restart : hold the counter at zero (asserted while the transmitter idles)
//   tick    : one-cycle pulse in the last cycle of each bit period
// -----------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_period
            $error("baud_tick_gen: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Held at zero during restart, so no tick can leak out while idle.
    assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/result_uart_tx.sv
// -----------------------------------------------------------------------------
// result_uart_tx
// Serialises result bytes from the arithmetic core as 8N1 UART frames
// (8E1 when RESULT_TX_PARITY_EN is defined: an even-parity bit sits between
// the data bits and the stop bit).
//   clk        : system clock (rising edge)
//   reset      : asynchronous, active-high; abandons any frame in progress
//   data_in    : result byte
//   data_valid : data_in is valid
//   data_ready : block can accept a byte (only while idle)
//   tx         : registered serial line, idle high
//   busy       : a frame is in progress
// Handshake: a byte is taken on the rising edge where data_valid && data_ready;
// data_ready is high only in IDLE, so inputs are ignored for the whole frame.
// The first start-bit cycle is the cycle right after acceptance, and after the
// stop bit the block spends exactly one cycle in IDLE before the next frame.
// Optional feature macro: RESULT_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module result_uart_tx
    import result_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t              state;
    logic [DATA_BITS-1:0]   shreg;
    logic [2:0]             bit_idx;
    logic                   tick;
    logic                   restart;
`ifdef RESULT_TX_PARITY_EN
    logic                   parity_bit;
`endif

    // The period counter sits at zero while idle so the start bit gets a
    // full CLKS_PER_BIT cycles starting right after acceptance.
    assign restart = (state == IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= IDLE_LEVEL;
            data_ready <= 1'b1;
            busy       <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
`ifdef RESULT_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (data_valid && data_ready) begin
                        shreg      <= data_in;
                        bit_idx    <= '0;
                        state      <= START;
                        tx         <= START_LEVEL;
                        data_ready <= 1'b0;
                        busy       <= 1'b1;
`ifdef RESULT_TX_PARITY_EN
                        parity_bit <= ^data_in;
`endif
                    end
                end

                START: begin
                    if (tick) begin
                        state <= DATA;
                        tx    <= shreg[0];
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
`ifdef RESULT_TX_PARITY_EN
                            state   <= PARITY;
                            tx      <= parity_bit;
`else
                            state   <= STOP;
                            tx      <= IDLE_LEVEL;
`endif
                        end else begin
                            // LSB first: shift down and present the next bit.
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                            tx      <= shreg[1];
                        end
                    end
                end

`ifdef RESULT_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        tx    <= IDLE_LEVEL;
                    end
                end
`endif

                STOP: begin
                    if (tick) begin
                        state      <= IDLE;
                        tx         <= IDLE_LEVEL;
                        data_ready <= 1'b1;
                        busy       <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    tx         <= IDLE_LEVEL;
                    data_ready <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_result_uart_tx
// Self-checking bench for result_uart_tx with CLKS_PER_BIT=4. Builds with or
// without RESULT_TX_PARITY_EN; expectations follow the macro.
// -----------------------------------------------------------------------------
module tb_result_uart_tx;

    localparam int N = 4;
`ifdef RESULT_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NBITS = PAR ? 11 : 10;
    localparam int FL    = NBITS * N;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx;
    logic       busy;

    always #5 clk = ~clk;

    result_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .tx        (tx),
        .busy      (busy)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [2:0] exp_q[$];   // per-cycle {tx, busy, data_ready}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is a list of line levels, one per bit period; while a frame is
    // pending the expected line level is the entry for the elapsed bit period.
    int          m_left = 0;      // cycles of frame still to run
    logic [10:0] m_bits = '0;     // index 0 = first transmitted bit
    int          m_accepts = 0;

    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        if (PAR) b[9] = ^d;
        return b;
    endfunction

    // One clock cycle driven from the negedge; checks outputs at next negedge.
    task automatic cycle(input logic v, input logic [7:0] d);
        logic acc;
        logic [2:0] e;
        data_valid = v;
        data_in    = d;
        acc = (m_left == 0) && v;
        @(posedge clk);
        if (m_left > 0) m_left--;
        if (acc) begin
            m_bits = frame_bits(d);
            m_left = FL;
            m_accepts++;
        end
        exp_q.push_back((m_left == 0) ? 3'b101 : {m_bits[(FL - m_left) / N], 2'b10});
        @(negedge clk);
        e = exp_q.pop_front();
        chk("cycle", {tx, busy, data_ready}, e);
    endtask

    // ---------------- table-driven frames ----------------
    typedef struct {
        logic [7:0]  data;
        logic [9:0]  seq_np;   // transmission order, leftmost first
        logic [10:0] seq_p;
    } vec_t;

    vec_t tbl[5];

    // Sends one byte (valid for a single cycle) and compares every cycle of
    // the frame against the literal bit sequence, then the idle cycle after.
    task automatic send_table(input logic [7:0] d, input logic [9:0] snp, input logic [10:0] sp);
        logic [10:0] s;
        s = PAR ? sp : {1'b0, snp};
        data_valid = 1'b1;
        data_in    = d;
        @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0;
        data_in    = 8'($urandom);
        for (int i = 0; i < NBITS; i++) begin
            for (int c = 0; c < N; c++) begin
                chk("tbl_frame", {tx, busy, data_ready}, {s[NBITS-1-i], 2'b10});
                @(negedge clk);
            end
        end
        chk("tbl_idle_after", {tx, busy, data_ready}, 3'b101);
    endtask

    int idle_between;

    // ---------------- main sequence ----------------
    initial begin
        tbl[0] = '{8'hA5, 10'b0101001011, 11'b01010010101};
        tbl[1] = '{8'h07, 10'b0111000001, 11'b01110000011};
        tbl[2] = '{8'h3C, 10'b0001111001, 11'b00011110001};
        tbl[3] = '{8'h80, 10'b0000000011, 11'b00000000111};
        tbl[4] = '{8'hFF, 10'b0111111111, 11'b01111111101};

        // Asynchronous reset: outputs settle with no clock edge.
        #1 reset = 1'b1;
        #1 chk("reset_async", {tx, busy, data_ready}, 3'b101);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        m_left = 0;

        // Quiet line for 100 cycles.
        for (int k = 0; k < 100; k++) cycle(1'b0, 8'($urandom));

        // Fixed frames with literal expected sequences.
        foreach (tbl[i]) send_table(tbl[i].data, tbl[i].seq_np, tbl[i].seq_p);

        // Back-to-back with data_valid held: exactly one idle cycle between.
        m_accepts    = 0;
        idle_between = 0;
        for (int k = 0; k < 3 * FL; k++) begin
            if (m_accepts >= 2 && m_left == 0) break;
            cycle(m_accepts < 2, (m_accepts == 0) ? 8'h3C : 8'hC3);
            if (m_accepts == 1 && !busy) idle_between++;
        end
        data_valid = 1'b0;
        chk("b2b_gap", 32'(idle_between), 32'd1);
        chk("b2b_done", {tx, busy, data_ready}, 3'b101);

        // data_in changes mid-frame: 0x11 must still go out intact.
        cycle(1'b1, 8'h11);
        for (int k = 0; k < FL - 2; k++) cycle(1'b1, 8'hFF);
        for (int k = 0; k < 3 * FL && m_left != 0; k++) cycle(1'b0, 8'h00);
        chk("chg_drained", {tx, busy, data_ready}, 3'b101);

        // Reset pulse between edges during data bit 3 of a 0x3C frame.
        data_valid = 1'b1;
        data_in    = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (4 * N + 1) @(negedge clk);
        chk("pre_reset_bit3", {tx, busy, data_ready}, 3'b110);
        #2 reset = 1'b1;
        #1 chk("reset_midframe", {tx, busy, data_ready}, 3'b101);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("after_reset_idle", {tx, busy, data_ready}, 3'b101);
        m_left = 0;
        exp_q.delete();
        send_table(8'h55, 10'b0101010101, 11'b01010101001);

        // Randomised traffic against the model.
        for (int k = 0; k < 2500; k++) cycle($urandom_range(0, 3) == 0, 8'($urandom));
        for (int k = 0; k < 3 * FL && m_left != 0; k++) cycle(1'b0, 8'h00);
        chk("random_drained", {tx, busy, data_ready}, 3'b101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
